// File: rtl/switch_confirm_ctrl.sv
// Confirm-button sequencer: synchronizes and debounces the confirm button, snapshots
// the switches once per press and serves them over the CPU IO read port.
// Optional sticky overrun status bit: define SWITCH_CONFIRM_OVERRUN_EN.
module switch_confirm_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter logic [31:0] DATA_ADDR       = 32'hFFFF_FFF1,
  parameter logic [31:0] STATUS_ADDR     = 32'hFFFF_FFFD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        confirm_raw,
  input  logic [15:0] switch_input,
  input  logic        read_en,
  input  logic [31:0] address,
  output logic [15:0] data_out,
  output logic        valid,
  output logic        confirm_pulse
);

  localparam int unsigned SW_W  = 16;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             capture_c;

  logic             sync_meta;
  logic             sync;

  logic [SW_W-1:0]  snapshot;
  logic             overrun;
  logic             data_rd_c;

  // Two-flop synchronizer for the asynchronous button pin
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= confirm_raw;
      sync      <= sync_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Debounce: a level change is accepted after DEBOUNCE_CYCLES stable cycles
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    capture_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_d   = HELD;
          capture_c = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        if (sync) begin
          state_d = HELD;
        end else if (cnt == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_rd_c = read_en && (address == DATA_ADDR);

  // Snapshot and pending flag; a capture on the consuming edge takes priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot      <= '0;
      valid         <= 1'b0;
      confirm_pulse <= 1'b0;
    end else begin
      confirm_pulse <= capture_c;
      if (capture_c) begin
        snapshot <= switch_input;
        valid    <= 1'b1;
      end else if (data_rd_c) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef SWITCH_CONFIRM_OVERRUN_EN
  logic status_rd_c;
  logic overrun_set_c;

  assign status_rd_c   = read_en && (address == STATUS_ADDR);
  assign overrun_set_c = capture_c && valid && !data_rd_c;

  // Sticky overrun: set beats a same-edge status-read clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (overrun_set_c) begin
      overrun <= 1'b1;
    end else if (status_rd_c) begin
      overrun <= 1'b0;
    end
  end
`else
  assign overrun = 1'b0;
`endif

  // IO read mux
  always_comb begin
    data_out = '0;
    if (read_en) begin
      if (address == DATA_ADDR) begin
        data_out = snapshot;
      end else if (address == STATUS_ADDR) begin
        data_out = {14'b0, overrun, valid};
      end
    end
  end

endmodule

// File: tb/tb_switch_confirm_ctrl.sv
// Scoreboard bench for switch_confirm_ctrl with DEBOUNCE_CYCLES=4: directed scenarios
// followed by randomized button/switch/read traffic against a run-length reference model.
module tb_switch_confirm_ctrl;

  localparam int unsigned DB = 4;
  localparam logic [31:0] DATA_A = 32'hFFFF_FFF1;
  localparam logic [31:0] STAT_A = 32'hFFFF_FFFD;

  logic        clk;
  logic        rst;
  logic        confirm_raw;
  logic [15:0] switch_input;
  logic        read_en;
  logic [31:0] address;
  logic [15:0] data_out;
  logic        valid;
  logic        confirm_pulse;

  switch_confirm_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .DATA_ADDR(DATA_A),
    .STATUS_ADDR(STAT_A)
  ) dut (
    .clk(clk),
    .rst(rst),
    .confirm_raw(confirm_raw),
    .switch_input(switch_input),
    .read_en(read_en),
    .address(address),
    .data_out(data_out),
    .valid(valid),
    .confirm_pulse(confirm_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  logic        m_h1, m_h2;
  logic        m_pressed;
  int          m_run;
  logic        m_valid;
  logic        m_ovr;
  logic [15:0] m_snap;
  int          cyc = 0;

  int          pulse_q[$];
  logic [15:0] data_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Button accepted as pressed/released after DB+1 consecutive synchronized samples
  // disagreeing with the current debounced level; sync lags the pin by two edges.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_h1 = 0; m_h2 = 0; m_pressed = 0; m_run = 0;
      m_valid = 0; m_ovr = 0; m_snap = '0;
      pulse_q.delete();
    end else begin
      logic s, capture, consume, stat, ov_set;
      s = m_h2; m_h2 = m_h1; m_h1 = confirm_raw;
      cyc++;
      capture = 0; ov_set = 0;
      if (s != m_pressed) m_run++;
      else m_run = 0;
      if (m_run == DB + 1) begin
        m_pressed = s;
        m_run = 0;
        capture = s;
      end
      consume = read_en && (address == DATA_A);
      stat    = read_en && (address == STAT_A);
      if (capture) begin
        ov_set  = m_valid && !consume;
        m_snap  = switch_input;
        m_valid = 1;
        pulse_q.push_back(cyc);
      end else if (consume) begin
        m_valid = 0;
      end
`ifdef SWITCH_CONFIRM_OVERRUN_EN
      if (ov_set) m_ovr = 1;
      else if (stat) m_ovr = 0;
`endif
    end
  end

  function automatic logic [15:0] exp_data(input logic re, input logic [31:0] a);
    if (!rst || !re) return 16'h0000;
    if (a == DATA_A) return m_snap;
    if (a == STAT_A) return {14'b0, m_ovr, m_valid};
    return 16'h0000;
  endfunction

  // Monitor: compares read data, pending flag and capture pulses every cycle
  always @(negedge clk) begin
    if (data_q.size() > 0) begin
      logic [15:0] e;
      e = data_q.pop_front();
      chk("data_out", 32'(data_out), 32'(e));
      chk("valid", 32'(valid), 32'(m_valid));
      if (confirm_pulse) begin
        if (pulse_q.size() > 0 && pulse_q[0] == cyc) begin
          chk("confirm_pulse", 32'(confirm_pulse), 32'd1);
          void'(pulse_q.pop_front());
        end else begin
          chk("unexpected_pulse", 32'(confirm_pulse), 32'd0);
        end
      end else if (pulse_q.size() > 0 && pulse_q[0] <= cyc) begin
        chk("missing_pulse", 32'(confirm_pulse), 32'd1);
        void'(pulse_q.pop_front());
      end
    end
  end

  task automatic step(input logic r, input logic c, input logic [15:0] s,
                      input logic re, input logic [31:0] a);
    @(posedge clk);
    #1;
    rst = r; confirm_raw = c; switch_input = s; read_en = re; address = a;
    data_q.push_back(exp_data(re, a));
  endtask

  task automatic press(input logic [15:0] s, input int hi, input int lo,
                       input logic re, input logic [31:0] a);
    repeat (hi) step(1, 1, s, re, a);
    repeat (lo) step(1, 0, s, re, a);
  endtask

  task automatic pattern(input logic [15:0] s, input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1, bits[i], s, 0, 32'h0);
  endtask

  initial begin
    rst = 0; confirm_raw = 1; switch_input = 16'h0; read_en = 0; address = 32'h0;
    // Reset held with button pressed, then released with button still held
    repeat (3) step(0, 1, 16'h0, 1, STAT_A);
    repeat (10) step(1, 1, 16'h1234, 0, 32'h0);
    repeat (8) step(1, 0, 16'h1234, 0, 32'h0);
    step(1, 0, 16'h0, 1, DATA_A);
    // Clean press then consume and re-read
    press(16'hA5C3, 8, 8, 0, 32'h0);
    step(1, 0, 16'h0, 1, STAT_A);
    step(1, 0, 16'h0, 1, DATA_A);
    step(1, 0, 16'h0, 1, DATA_A);
    step(1, 0, 16'h0, 1, STAT_A);
    step(1, 0, 16'h0, 1, 32'h0000_1234);
    // Bounce rejection, then a real press
    pattern(16'h5A5A, 32'b1110110000000000, 16);
    step(1, 0, 16'h0, 1, STAT_A);
    press(16'h5A5A, 8, 8, 0, 32'h0);
    step(1, 0, 16'h0, 1, DATA_A);
    // Long hold with glitchy release
    repeat (50) step(1, 1, 16'hBEEF, 0, 32'h0);
    pattern(16'hBEEF, 32'b0011001100000000, 16);
    step(1, 0, 16'h0, 1, DATA_A);
    // Two presses without a read between
    press(16'h0001, 8, 8, 0, 32'h0);
    press(16'h0002, 8, 8, 0, 32'h0);
    step(1, 0, 16'h0, 1, STAT_A);
    step(1, 0, 16'h0, 1, STAT_A);
    step(1, 0, 16'h0, 1, DATA_A);
    step(1, 0, 16'h0, 1, STAT_A);
    // Capture on an edge that also consumes
    press(16'h0003, 8, 8, 0, 32'h0);
    press(16'h0004, 8, 0, 1, DATA_A);
    step(1, 0, 16'h0, 1, STAT_A);
    repeat (8) step(1, 0, 16'h0, 0, 32'h0);
    step(1, 0, 16'h0, 1, DATA_A);
    // Reset mid-debounce with button held
    repeat (4) step(1, 1, 16'h7777, 0, 32'h0);
    repeat (2) step(0, 1, 16'h7777, 0, 32'h0);
    repeat (10) step(1, 1, 16'h8888, 0, 32'h0);
    repeat (8) step(1, 0, 16'h8888, 1, STAT_A);
    // Randomized traffic
    begin
      logic        lvl;
      logic [15:0] sw;
      lvl = 0; sw = 16'(($urandom));
      for (int n = 0; n < 1500; ) begin
        int run;
        run = int'($urandom_range(1, 9));
        if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
        for (int k = 0; k < run; k++) begin
          logic        re, r;
          logic [31:0] a;
          int          sel;
          sel = int'($urandom_range(0, 7));
          re  = (sel < 3);
          a   = (sel == 0) ? DATA_A : (sel == 1) ? STAT_A : 32'($urandom);
          r   = ($urandom_range(0, 299) != 0);
          step(r, lvl, sw, re, a);
          n++;
        end
        lvl = ~lvl;
      end
    end
    repeat (12) step(1, 0, 16'h0, 0, 32'h0);
    @(negedge clk);
    #1;
    chk("pulse_queue_empty", 32'(pulse_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/switch_confirm_ctrl.md
Name: switch_confirm_ctrl

Overview:
- Sequences user input from the board switches into the CPU's memory-mapped IO space.
- Synchronizes and debounces the confirm push-button, then snapshots the 16 switches on each debounced press.
- Holds the snapshot with a valid flag until the CPU consumes it by reading the data address.
- Sits between the board pins and the IO read mux, in front of the switch data path; gives polled, one-shot input per button press.

Parameters:
- DEBOUNCE_CYCLES, 20000: consecutive synchronized-stable cycles needed to accept a level change on the confirm button; legal range 1..65535.
- DATA_ADDR, 32'hFFFF_FFF1: read address returning the latched switch snapshot; a read here consumes it.
- STATUS_ADDR, 32'hFFFF_FFFD: read address returning status bits.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset.
- confirm_raw  input  1  confirm push-button pin, asynchronous, high = pressed.
- switch_input  input  16  raw switch pins.
- read_en  input  1  CPU IO-read strobe for this cycle.
- address  input  32  CPU IO address.
- data_out  output  16  read data; combinational from internal registers.
- valid  output  1  snapshot pending, not yet consumed (also drives an LED).
- confirm_pulse  output  1  one-cycle pulse on the capture edge.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, sync flops=0, snapshot=16'h0000, valid=0, overrun=0, confirm_pulse=0.
- Synchronizer: 2-flop chain on confirm_raw; its output is sync.
- FSM states, checked at each posedge:
  - IDLE: if sync=1, go to PRESS_DB with cnt=0.
  - PRESS_DB: if sync=0, go to IDLE (bounce rejected). Else if cnt==DEBOUNCE_CYCLES-1, go to HELD and capture. Else cnt+1.
  - HELD: if sync=0, go to RELEASE_DB with cnt=0.
  - RELEASE_DB: if sync=1, go to HELD. Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE. Else cnt+1.
- Capture (on the PRESS_DB->HELD edge):
  - snapshot<=switch_input; valid<=1; confirm_pulse=1 for exactly that cycle.
  - Only one capture per press; holding the button captures nothing further.
- Latency: confirm_raw held high from edge e gives capture at edge e+2+DEBOUNCE_CYCLES.
- Counter: 16 bits, saturating is not required; it is never incremented past DEBOUNCE_CYCLES-1.
- Read decode (read_en=1):
  - address==DATA_ADDR: data_out=snapshot.
  - address==STATUS_ADDR: data_out={14'b0, overrun, valid}.
  - any other address, or read_en=0: data_out=16'h0000.
- Consume: a posedge with read_en=1 and address==DATA_ADDR clears valid. The snapshot value is retained; a re-read returns the same data.
- Simultaneous consume and capture on one edge: capture wins. New snapshot, valid=1, no overrun.
- Capture while valid=1 and no same-edge consume: snapshot is overwritten, valid stays 1, overrun event raised (see optional feature).
- Reset mid-debounce or mid-press: everything returns to reset values. A button still held after release of rst is treated as a new press, re-debounced from IDLE.
- Switch inputs are sampled unsynchronized at capture; the user holds the switches steady before pressing.

Optional Feature:
- Macro: SWITCH_CONFIRM_OVERRUN_EN.
- Defined:
  - overrun is a sticky flag, set on any capture while valid=1 without a same-edge consume.
  - Cleared by a posedge with read_en=1 and address==STATUS_ADDR; a set on that same edge wins.
  - Status bit1 reflects it.
- Undefined: no overrun register exists; status bit1 always reads 0.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then idle: rst=0 with confirm_raw=1 -> valid=0, data_out=0, state IDLE. Release rst and hold the button -> capture 6 edges later.
- Clean press: switch_input=16'hA5C3, confirm_raw rises at edge e -> confirm_pulse=1 at edge e+6 only, valid=1. DATA_ADDR read returns 16'hA5C3 and valid clears on that edge.
- Bounce rejection: confirm_raw high 3 cycles, low 1, high 2, then low -> no capture, valid stays 0. Then high 6+ cycles -> exactly one capture.
- Hold and release: button held 50 cycles, then released with 2-cycle glitches -> exactly one confirm_pulse; FSM returns to IDLE only after 4 stable low cycles.
- Overrun (macro defined): two presses with switches 16'h0001 then 16'h0002, no read between -> status reads 16'h0003. The status read clears overrun, so the next status read gives 16'h0001. Data read returns 16'h0002.
- Same-edge consume and capture: DATA_ADDR read on the capture edge -> valid=1, new snapshot visible, overrun=0.
